reg_wb_sink: RTL and testbench
==============================

REG_WB_SINK -- requirements
Module: reg_wb_sink

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data word width.
REQ-002 The block SHALL have parameter NREG, default 32, meaning the number of architectural registers (address width AW = clog2(NREG)).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 wb_we  in  1  writeback register-write enable from the WB stage register.
REQ-006 wb_rd  in  AW  writeback destination register.
REQ-007 wb_mem2reg  in  1  1 selects load data, 0 selects ALU result.
REQ-008 wb_alu  in  XLEN  ALU result from the WB stage.
REQ-009 wb_mem  in  XLEN  load data from the WB stage.
REQ-010 iss_vld  in  1  the decode stage issues an instruction this cycle.
REQ-011 iss_we  in  1  the issued instruction writes a register.
REQ-012 iss_rd  in  AW  destination of the issued instruction.
REQ-013 rs1, rs2  in  AW each  source read addresses.
REQ-014 rd1, rd2  out  XLEN each  source read data.
REQ-015 stall  out  1  a source is pending; decode SHALL hold.
REQ-016 sb_err  out  1  sticky scoreboard overflow/underflow flag.

Function
REQ-017 Writeback data SHALL be wd = wb_mem2reg ? wb_mem : wb_alu.
REQ-018 The register array SHALL be written at posedge clk when wb_we=1 and wb_rd!=0.
REQ-019 Register 0 SHALL read as 0 at all times; writes to it are discarded and leave the scoreboard unchanged.
REQ-020 Reads SHALL be combinational; a read of rsN==wb_rd with wb_we=1 and rsN!=0 SHALL return wd in the same cycle (write-through bypass).
REQ-021 Each register 1..NREG-1 SHALL have a 2-bit pending counter.
REQ-022 The counter for iss_rd SHALL increment when iss_vld=1 and iss_we=1 and stall=0 and iss_rd!=0.
REQ-023 The counter for wb_rd SHALL decrement when wb_we=1 and wb_rd!=0.
REQ-024 An increment and a decrement of the same counter in one cycle SHALL leave it unchanged.
REQ-025 An increment at count 3 SHALL saturate at 3 and set sb_err.
REQ-026 A decrement at count 0 SHALL hold at 0 and set sb_err.
REQ-027 stall SHALL be 1 when, for rs1 or rs2 (nonzero), count>1, or count==1 and not (wb_we=1 and wb_rd==rsN); otherwise 0.
REQ-028 stall SHALL be combinational from the current counters and WB inputs, with no registered latency.
REQ-029 Issue is ignored while stall=1 (REQ-022), so a held instruction does not double-count.
REQ-030 sb_err SHALL stay 1 until reset.

Reset
REQ-031 On rst=0, all registers, all pending counters and sb_err SHALL clear to 0 asynchronously.
REQ-032 Consequently stall SHALL be 0 while rst=0.
REQ-033 Writes and issues presented while rst=0 SHALL be discarded.
REQ-034 Normal operation SHALL resume on the first posedge after rst returns to 1.

Structure
REQ-035 Package rf_pkg SHALL hold XLEN, NREG and AW, the typedefs word_t and raddr_t, and the typedef pend_t (2-bit).
REQ-036 The pending counters and stall/sb_err logic SHALL be the sub-module wb_scoreboard; the array, bypass and data mux SHALL remain in reg_wb_sink.

Verification
REQ-037 Reset then write x5=0xDEADBEEF (wb_mem2reg=0) -> next cycle rs1=5 gives rd1=0xDEADBEEF; a write to x0 of 0x1234 -> rd2 for rs2=0 remains 0.
REQ-038 wb_we=1, wb_rd=7, wb_mem2reg=1, wb_mem=0xA5A5A5A5, rs2=7 in the same cycle -> rd2=0xA5A5A5A5 combinationally.
REQ-039 Issue rd=3, next cycle rs1=3 with no WB -> stall=1; then WB to x3 -> stall=0 that cycle, and the counter is 0 the next cycle.
REQ-040 Issue rd=4 and WB rd=4 in the same cycle with count=1 -> count stays 1 and stall stays 1 for rs1=4.
REQ-041 Four issues to x9 with no WB -> count=3 and sb_err=1; WB to x2 at count 0 -> sb_err=1.
REQ-042 Assert rst=0 mid-stream with counters nonzero -> stall=0, sb_err=0 and rd1=0 immediately, without a clock edge.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg -- shared sizing and types for the writeback register file and its
// pending-write scoreboard.
//
// Contents:
//   XLEN, NREG, AW : default data width, register count and address width
//   word_t         : one data word
//   raddr_t        : one register address
//   pend_t         : 2-bit pending-write counter
//   PEND_MAX       : saturation value of pend_t
package rf_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [XLEN-1:0] word_t;
  typedef logic [AW-1:0]   raddr_t;
  typedef logic [1:0]      pend_t;

  localparam pend_t PEND_MAX = 2'd3;

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard -- per-register pending-write counters for an in-order
// pipeline. Decode bumps the counter of its destination on issue, writeback
// drops it, and decode is told to hold while either source still has a
// write in flight that is not being completed this very cycle.
//
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   wb_we, wb_rd   : writeback register write (decrements counter of wb_rd)
//   iss_vld/we/rd  : issued instruction (increments counter of iss_rd)
//   rs1, rs2       : source addresses of the instruction in decode
//   stall          : combinational hold request for decode
//   sb_err         : sticky counter overflow/underflow flag
module wb_scoreboard #(
  parameter int NREG = rf_pkg::NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rd,
  input  logic          iss_vld,
  input  logic          iss_we,
  input  logic [AW-1:0] iss_rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          stall,
  output logic          sb_err
);

  import rf_pkg::*;

  // One slot per encodable address so any rsN indexes in range; slot 0 and
  // slots at or above NREG never count and stay at zero.
  localparam int NSLOT = 1 << AW;

  pend_t            pend_q [NSLOT];
  logic [NSLOT-1:0] err_vec;
  logic             iss_ok;
  logic             stall1;
  logic             stall2;
  pend_t            cnt1;
  pend_t            cnt2;
  logic             sb_err_q;
  logic             sb_err_d;

  // A source with one write outstanding is released in the same cycle as
  // that write lands, because the register file bypasses wd to the reader.
  always_comb begin
    cnt1   = pend_q[rs1];
    cnt2   = pend_q[rs2];
    stall1 = 1'b0;
    stall2 = 1'b0;
    if (rs1 != '0) begin
      stall1 = (cnt1 > 2'd1) || ((cnt1 == 2'd1) && !(wb_we && (wb_rd == rs1)));
    end
    if (rs2 != '0) begin
      stall2 = (cnt2 > 2'd1) || ((cnt2 == 2'd1) && !(wb_we && (wb_rd == rs2)));
    end
    stall  = stall1 | stall2;
    // A held instruction must not count again on every stalled cycle.
    iss_ok = iss_vld && iss_we && !stall && (iss_rd != '0);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_cnt
      localparam bit LIVE = (gi != 0) && (gi < NREG);

      pend_t cnt_q;
      pend_t cnt_d;
      logic  inc;
      logic  dec;
      logic  err;

      assign inc = LIVE && iss_ok && (iss_rd == AW'(gi));
      assign dec = LIVE && wb_we && (wb_rd == AW'(gi));

      // Simultaneous inc and dec cancel out, so neither limit can trip.
      always_comb begin
        cnt_d = cnt_q;
        err   = 1'b0;
        if (inc && !dec) begin
          if (cnt_q == PEND_MAX) begin
            err = 1'b1;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (dec && !inc) begin
          if (cnt_q == 2'd0) begin
            err = 1'b1;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign pend_q[gi]  = cnt_q;
      assign err_vec[gi] = err;
    end
  endgenerate

  always_comb begin
    sb_err_d = sb_err_q | (|err_vec);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_err_q <= 1'b0;
    end else begin
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

endmodule

// File: rtl/reg_wb_sink.sv
// reg_wb_sink -- architectural register file fed by the writeback stage,
// with two combinational read ports, write-through bypass and a pending-
// write scoreboard that stalls decode on unresolved sources.
//
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   wb_we, wb_rd       : writeback write enable and destination
//   wb_mem2reg         : 1 selects wb_mem, 0 selects wb_alu as write data
//   wb_alu, wb_mem     : candidate write data
//   iss_vld/we/rd      : instruction issued from decode this cycle
//   rs1, rs2           : read addresses
//   rd1, rd2           : read data (x0 always reads zero)
//   stall              : decode must hold
//   sb_err             : sticky scoreboard overflow/underflow flag
module reg_wb_sink #(
  parameter int XLEN = rf_pkg::XLEN,
  parameter int NREG = rf_pkg::NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic            wb_mem2reg,
  input  logic [XLEN-1:0] wb_alu,
  input  logic [XLEN-1:0] wb_mem,
  input  logic            iss_vld,
  input  logic            iss_we,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            stall,
  output logic            sb_err
);

  // Every encodable address owns a slot so reads never index out of range;
  // slot 0 and slots at or above NREG are never written.
  localparam int NSLOT = 1 << AW;

  logic [XLEN-1:0] regs_q [NSLOT];
  logic [XLEN-1:0] wd;
  logic            wr_en;
  logic            byp_en;

  always_comb begin
    wd     = wb_mem2reg ? wb_mem : wb_alu;
    wr_en  = wb_we && (wb_rd != '0);
    // Bypass is suppressed in reset so reads fall to the cleared array at once.
    byp_en = wr_en && rst;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_reg
      localparam bit LIVE = (gi != 0) && (gi < NREG);

      logic [XLEN-1:0] reg_q;
      logic [XLEN-1:0] reg_d;

      always_comb begin
        reg_d = reg_q;
        if (LIVE && wr_en && (wb_rd == AW'(gi))) begin
          reg_d = wd;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign regs_q[gi] = reg_q;
    end
  endgenerate

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != '0) begin
      rd1 = (byp_en && (wb_rd == rs1)) ? wd : regs_q[rs1];
    end
    if (rs2 != '0) begin
      rd2 = (byp_en && (wb_rd == rs2)) ? wd : regs_q[rs2];
    end
  end

  wb_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .iss_vld (iss_vld),
    .iss_we  (iss_we),
    .iss_rd  (iss_rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .stall   (stall),
    .sb_err  (sb_err)
  );

endmodule

// File: tb/tb_reg_wb_sink.sv
module tb_reg_wb_sink;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic            wb_mem2reg;
  logic [XLEN-1:0] wb_alu;
  logic [XLEN-1:0] wb_mem;
  logic            iss_vld;
  logic            iss_we;
  logic [AW-1:0]   iss_rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            stall;
  logic            sb_err;

  int checks = 0;
  int errors = 0;

  reg_wb_sink #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_mem2reg (wb_mem2reg),
    .wb_alu     (wb_alu),
    .wb_mem     (wb_mem),
    .iss_vld    (iss_vld),
    .iss_we     (iss_we),
    .iss_rd     (iss_rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd1        (rd1),
    .rd2        (rd2),
    .stall      (stall),
    .sb_err     (sb_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    iss_vld = 1'b1; iss_we = 1'b1; iss_rd = rd;
    step();
    iss_vld = 1'b0; iss_we = 1'b0; iss_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_we = 0; wb_rd = 0; wb_mem2reg = 0; wb_alu = 0; wb_mem = 0;
    iss_vld = 0; iss_we = 0; iss_rd = 0; rs1 = 5; rs2 = 0;
    #2 rst = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err got=%b exp=0", sb_err); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got=%h exp=0", rd1); end
    step(); step();
    rst = 1'b1;
    $display("reset: stall=%b sb_err=%b rd1=%h", stall, sb_err, rd1);
  endtask

  task automatic test_write_read();
    rs1 = 0; rs2 = 0;
    issue(5);
    wb_we = 1; wb_rd = 5; wb_mem2reg = 0; wb_alu = 32'hDEADBEEF; wb_mem = 32'h0;
    step();
    wb_we = 0; rs1 = 5;
    #1;
    checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_x5 got=%h exp=deadbeef", rd1); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL write_x5_stall got=%b exp=0", stall); end
    wb_we = 1; wb_rd = 0; wb_alu = 32'h1234; rs2 = 0;
    #1;
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL x0_bypass got=%h exp=0", rd2); end
    step();
    wb_we = 0;
    #1;
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL x0_read got=%h exp=0", rd2); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL x0_no_sb got=%b exp=0", sb_err); end
    $display("write_read: rd1=%h rd2=%h sb_err=%b", rd1, rd2, sb_err);
  endtask

  task automatic test_bypass();
    rs1 = 0; rs2 = 0;
    issue(7);
    wb_we = 1; wb_rd = 7; wb_mem2reg = 1; wb_mem = 32'hA5A5A5A5; wb_alu = 32'h11111111; rs2 = 7;
    #1;
    checks++; if (rd2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_mem got=%h exp=a5a5a5a5", rd2); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bypass_stall got=%b exp=0", stall); end
    step();
    wb_we = 0; wb_mem2reg = 0;
    #1;
    checks++; if (rd2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL stored_x7 got=%h exp=a5a5a5a5", rd2); end
    $display("bypass: rd2=%h stall=%b", rd2, stall);
  endtask

  task automatic test_stall();
    rs1 = 0; rs2 = 0;
    issue(3);
    rs1 = 3;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pend_x3 got=%b exp=1", stall); end
    step();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pend_x3_hold got=%b exp=1", stall); end
    wb_we = 1; wb_rd = 3; wb_alu = 32'h33;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wb_x3_release got=%b exp=0", stall); end
    step();
    wb_we = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x3_after got=%b exp=0", stall); end
    checks++; if (dut.u_sb.pend_q[3] !== 2'd0) begin errors++; $display("FAIL cnt_x3 got=%0d exp=0", dut.u_sb.pend_q[3]); end
    checks++; if (rd1 !== 32'h33) begin errors++; $display("FAIL x3_data got=%h exp=33", rd1); end
    $display("stall: stall=%b cnt3=%0d rd1=%h", stall, dut.u_sb.pend_q[3], rd1);
  endtask

  task automatic test_same_cycle();
    rs1 = 0; rs2 = 0;
    issue(4);
    checks++; if (dut.u_sb.pend_q[4] !== 2'd1) begin errors++; $display("FAIL cnt_x4_one got=%0d exp=1", dut.u_sb.pend_q[4]); end
    iss_vld = 1; iss_we = 1; iss_rd = 4; wb_we = 1; wb_rd = 4; wb_alu = 32'h44;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL same_cycle_stall got=%b exp=0", stall); end
    step();
    iss_vld = 0; iss_we = 0; wb_we = 0; rs1 = 4;
    #1;
    checks++; if (dut.u_sb.pend_q[4] !== 2'd1) begin errors++; $display("FAIL cnt_x4_kept got=%0d exp=1", dut.u_sb.pend_q[4]); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL x4_stall got=%b exp=1", stall); end
    wb_we = 1; wb_rd = 4;
    step();
    wb_we = 0;
    #1;
    checks++; if (dut.u_sb.pend_q[4] !== 2'd0) begin errors++; $display("FAIL cnt_x4_zero got=%0d exp=0", dut.u_sb.pend_q[4]); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL same_cycle_sb got=%b exp=0", sb_err); end
    $display("same_cycle: cnt4=%0d stall=%b sb_err=%b", dut.u_sb.pend_q[4], stall, sb_err);
  endtask

  task automatic test_stall_blocks_issue();
    rs1 = 0; rs2 = 0;
    issue(6);
    rs1 = 6; iss_vld = 1; iss_we = 1; iss_rd = 10;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL held_stall got=%b exp=1", stall); end
    step();
    iss_vld = 0; iss_we = 0;
    #1;
    checks++; if (dut.u_sb.pend_q[10] !== 2'd0) begin errors++; $display("FAIL held_no_count got=%0d exp=0", dut.u_sb.pend_q[10]); end
    wb_we = 1; wb_rd = 6;
    step();
    wb_we = 0; rs1 = 0;
    $display("stall_blocks_issue: cnt10=%0d", dut.u_sb.pend_q[10]);
  endtask

  task automatic test_saturate();
    rs1 = 0; rs2 = 0;
    iss_vld = 1; iss_we = 1; iss_rd = 9;
    step();
    step();
    rs1 = 9; wb_we = 1; wb_rd = 9;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cnt2_wb_stall got=%b exp=1", stall); end
    rs1 = 0; wb_we = 0;
    step();
    checks++; if (dut.u_sb.pend_q[9] !== 2'd3) begin errors++; $display("FAIL cnt_x9_three got=%0d exp=3", dut.u_sb.pend_q[9]); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL pre_sat_sb got=%b exp=0", sb_err); end
    step();
    iss_vld = 0; iss_we = 0;
    checks++; if (dut.u_sb.pend_q[9] !== 2'd3) begin errors++; $display("FAIL cnt_x9_sat got=%0d exp=3", dut.u_sb.pend_q[9]); end
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL overflow_sb got=%b exp=1", sb_err); end
    wb_we = 1; wb_rd = 2;
    step();
    wb_we = 0;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL sticky_sb got=%b exp=1", sb_err); end
    $display("saturate: cnt9=%0d sb_err=%b", dut.u_sb.pend_q[9], sb_err);
  endtask

  task automatic test_reset_mid();
    rs1 = 9; rs2 = 5;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall got=%b exp=1", stall); end
    checks++; if (rd2 !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_x5 got=%h exp=deadbeef", rd2); end
    #1 rst = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL async_stall got=%b exp=0", stall); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL async_sb got=%b exp=0", sb_err); end
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL async_rd2 got=%h exp=0", rd2); end
    wb_we = 1; wb_rd = 12; wb_alu = 32'h12121212; iss_vld = 1; iss_we = 1; iss_rd = 13; rs1 = 12;
    #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_bypass got=%h exp=0", rd1); end
    step();
    rst = 1'b1; wb_we = 0; iss_vld = 0; iss_we = 0;
    #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL discarded_wr got=%h exp=0", rd1); end
    checks++; if (dut.u_sb.pend_q[13] !== 2'd0) begin errors++; $display("FAIL discarded_iss got=%0d exp=0", dut.u_sb.pend_q[13]); end
    $display("reset_mid: stall=%b sb_err=%b rd1=%h", stall, sb_err, rd1);
  endtask

  task automatic test_underflow();
    rs1 = 0; rs2 = 0;
    wb_we = 1; wb_rd = 2; wb_alu = 32'h22;
    step();
    wb_we = 0;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL underflow_sb got=%b exp=1", sb_err); end
    checks++; if (dut.u_sb.pend_q[2] !== 2'd0) begin errors++; $display("FAIL underflow_cnt got=%0d exp=0", dut.u_sb.pend_q[2]); end
    step();
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL underflow_sticky got=%b exp=1", sb_err); end
    $display("underflow: sb_err=%b cnt2=%0d", sb_err, dut.u_sb.pend_q[2]);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_stall();
    test_same_cycle();
    test_stall_blocks_issue();
    test_saturate();
    test_reset_mid();
    test_underflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
